// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port from NUM_REQ requesters.
// Optional per-requester beat statistics enabled by defining ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [2:0]                    owner,
  output logic [NUM_REQ*16-1:0]         beat_count
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [2:0]            owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [3:0]            burst_q, burst_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q, sel_data;

  logic                  own_req, stall, accept, last_beat, release_c, any_req;
  logic [2:0]            next_ptr, arb_ptr, win_off, win_idx;
  logic [3:0]            win_sum;
  logic [NUM_REQ-1:0]    rot_req, win_oh;

  always_comb begin
    own_req  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // almost_full still leaves one slot, so only the beat already in flight must block
  assign stall     = fifo_full | (fifo_almost_full & wr_en_q);
  assign accept    = (state_q == GRANT) & own_req & ~stall;
  assign last_beat = accept & (burst_q == 4'(BURST_LEN - 1));
  assign release_c = (state_q == GRANT) & (~own_req | last_beat);
  assign next_ptr  = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
  assign arb_ptr   = (state_q == GRANT) ? next_ptr : rr_ptr_q;
  assign any_req   = |req;

  // Rotate so arb_ptr sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot_req = NUM_REQ'({req, req} >> arb_ptr);
    win_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) win_off = 3'(k);
    end
    win_sum = {1'b0, arb_ptr} + {1'b0, win_off};
    win_idx = (win_sum >= 4'(NUM_REQ)) ? 3'(win_sum - 4'(NUM_REQ)) : win_sum[2:0];
    for (int i = 0; i < NUM_REQ; i++) win_oh[i] = (win_idx == 3'(i));
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          owner_d = win_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          rr_ptr_d = next_ptr;
          burst_d  = '0;
          if (any_req) begin
            gnt_d   = win_oh;
            owner_d = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (accept) begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      wr_en_q  <= accept;
      if (accept) wr_data_q <= sel_data;
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;

`ifdef ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else if (accept && owner_q == 3'(g) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign beat_count[g*16 +: 16] = cnt_q;
  end
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full, fifo_almost_full, fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [2:0]  owner;
  logic [63:0] beat_count;
  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .owner(owner), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    int o;
    rst = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
    chk("rst_wr_data", 64'(fifo_wr_data), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_beat_count", beat_count, 64'h0);
    rst = 1'b1;

    // single requester, 10 beats of data 1..10, grant never drops
    @(negedge clk);
    req = 4'b0001; req_data[7:0] = 8'd1;
    @(negedge clk);
    chk("t1_gnt_first", 64'(gnt), 64'h1);
    chk("t1_wr_en_first", 64'(fifo_wr_en), 64'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("t1_wr_en_%0d", k), 64'(fifo_wr_en), 64'h1);
      chk($sformatf("t1_data_%0d", k), 64'(fifo_wr_data), 64'(k));
      chk($sformatf("t1_gnt_%0d", k), 64'(gnt), 64'h1);
      req_data[7:0] = 8'(k + 1);
      if (k == 10) req = 4'b0000;
    end
    @(negedge clk);
    chk("t1_gnt_end", 64'(gnt), 64'h0);
    chk("t1_wr_en_end", 64'(fifo_wr_en), 64'h0);

    // all requesting: bursts of 4 in order 0,1,2,3,0 with no gap
    do_reset();
    @(negedge clk);
    req = 4'b1111; req_data = 32'h13121110;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o = ((k - 1) / 4) % 4;
      eg = 4'b0001 << o;
      chk($sformatf("t2_gnt_%0d", k), 64'(gnt), 64'(eg));
      chk($sformatf("t2_owner_%0d", k), 64'(owner), 64'(o));
      if (k == 1) chk("t2_wr_en_1", 64'(fifo_wr_en), 64'h0);
      else begin
        chk($sformatf("t2_wr_en_%0d", k), 64'(fifo_wr_en), 64'h1);
        chk($sformatf("t2_data_%0d", k), 64'(fifo_wr_data), 64'(8'h10 + ((k - 2) / 4) % 4));
      end
    end
    req = 4'b0000;

    // owner 0 drops its request after 2 beats, grant moves straight to 2
    do_reset();
    @(negedge clk);
    req = 4'b0101; req_data = 32'h00_22_00_01;
    repeat (3) @(negedge clk);
    chk("t3_wr_en_beat2", 64'(fifo_wr_en), 64'h1);
    req = 4'b0100;
    @(negedge clk);
    chk("t3_gnt", 64'(gnt), 64'h4);
    chk("t3_owner", 64'(owner), 64'h2);
    chk("t3_wr_en", 64'(fifo_wr_en), 64'h0);
    chk("t3_rr_ptr", 64'(dut.rr_ptr_q), 64'h1);
    req = 4'b0000;

    // fifo_full stall during grant to 1, then almost_full back-pressure
    do_reset();
    @(negedge clk);
    req = 4'b0010; req_data[15:8] = 8'h21;
    @(negedge clk);
    chk("t4_gnt", 64'(gnt), 64'h2);
    @(negedge clk);
    chk("t4_data1", 64'(fifo_wr_data), 64'h21);
    req_data[15:8] = 8'h22;
    @(negedge clk);
    chk("t4_data2", 64'(fifo_wr_data), 64'h22);
    fifo_full = 1'b1; req_data[15:8] = 8'h23;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_wr_en_%0d", k), 64'(fifo_wr_en), 64'h0);
      chk($sformatf("t4_stall_gnt_%0d", k), 64'(gnt), 64'h2);
      chk($sformatf("t4_stall_data_%0d", k), 64'(fifo_wr_data), 64'h22);
    end
    chk("t4_burst_held", 64'(dut.burst_q), 64'h2);
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t4_data3", 64'(fifo_wr_data), 64'h23);
    chk("t4_wr_en3", 64'(fifo_wr_en), 64'h1);
    req_data[15:8] = 8'h24;
    @(negedge clk);
    chk("t4_data4", 64'(fifo_wr_data), 64'h24);
    chk("t4_regrant", 64'(gnt), 64'h2);
    chk("t4_burst_new", 64'(dut.burst_q), 64'h0);
    fifo_almost_full = 1'b1; req_data[15:8] = 8'h25;
    @(negedge clk);
    chk("t4_af_wr_en_blocked", 64'(fifo_wr_en), 64'h0);
    chk("t4_af_data_held", 64'(fifo_wr_data), 64'h24);
    @(negedge clk);
    chk("t4_af_wr_en_ok", 64'(fifo_wr_en), 64'h1);
    chk("t4_af_data", 64'(fifo_wr_data), 64'h25);
    fifo_almost_full = 1'b0; req = 4'b0000;

    // reset asserted mid-burst, then first grant follows from rr_ptr=0
    do_reset();
    @(negedge clk);
    req = 4'b1000; req_data[31:24] = 8'h31;
    repeat (3) @(negedge clk);
    chk("t5_pre_wr_en", 64'(fifo_wr_en), 64'h1);
    chk("t5_pre_owner", 64'(owner), 64'h3);
    rst = 1'b0;
    #1;
    chk("t5_gnt", 64'(gnt), 64'h0);
    chk("t5_wr_en", 64'(fifo_wr_en), 64'h0);
    chk("t5_wr_data", 64'(fifo_wr_data), 64'h0);
    chk("t5_owner", 64'(owner), 64'h0);
    chk("t5_beat_count", beat_count, 64'h0);
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_first_gnt", 64'(gnt), 64'h2);
    chk("t5_first_owner", 64'(owner), 64'h1);
    req = 4'b0000;

    // 20 beats from requester 3 for the statistics counters
    do_reset();
    @(negedge clk);
    req = 4'b1000;
    repeat (21) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
`ifdef ARB_STATS_EN
    chk("t6_beat_count", beat_count, {16'd20, 48'h0});
`else
    chk("t6_beat_count", beat_count, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of each requester's data and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning maximum beats per grant before forced rotation (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request, bit i = requester i.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  flat data bus, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port gnt  output  NUM_REQ  registered one-hot grant (all-zero when no owner).
REQ-009 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-010 SHALL have port fifo_almost_full  input  1  FIFO almost-full flag (asserts with at least one free entry).
REQ-011 SHALL have port fifo_wr_en  output  1  registered FIFO write enable.
REQ-012 SHALL have port fifo_wr_data  output  DATA_WIDTH  registered FIFO write data.
REQ-013 SHALL have port owner  output  3  index of current grant holder, valid when gnt != 0.
REQ-014 SHALL have port beat_count  output  NUM_REQ*16  per-requester accepted-beat counters (see Configuration).

Function
REQ-015 SHALL implement states IDLE (gnt=0) and GRANT (gnt one-hot to owner).
REQ-016 SHALL, in IDLE with any req bit set, select the first set req bit searching from rr_ptr upward with wrap-around, enter GRANT next cycle, and clear the burst counter.
REQ-017 SHALL define stall = fifo_full | (fifo_almost_full & fifo_wr_en).
REQ-018 SHALL accept a beat in any cycle where gnt[i] & req[i] & !stall, registering fifo_wr_en=1 and fifo_wr_data=req_data slice i on that edge (latency 1 cycle from acceptance).
REQ-019 SHALL drive fifo_wr_en=0 on every edge with no accepted beat; fifo_wr_data holds its last value.
REQ-020 SHALL increment the 4-bit burst counter per accepted beat; grant is held across stall cycles without counting.
REQ-021 SHALL release the grant after the edge where the burst counter reaches BURST_LEN, or when req[owner]=0 (sampled while granted), setting rr_ptr = (owner+1) mod NUM_REQ.
REQ-022 SHALL, on release, re-arbitrate the same cycle: if any req is set, grant the next winner from the new rr_ptr directly (GRANT to GRANT, no IDLE bubble); otherwise go to IDLE.
REQ-023 SHALL, when only one requester is active, re-grant it after each BURST_LEN burst with zero idle cycles.
REQ-024 SHALL never assert more than one gnt bit, and never assert fifo_wr_en on an edge where fifo_full was high at acceptance.

Reset
REQ-025 SHALL, on rst low, immediately force: state=IDLE, gnt=0, owner=0, rr_ptr=0, burst counter=0, fifo_wr_en=0, fifo_wr_data=0, beat_count=0.
REQ-026 SHALL discard any in-flight beat when reset asserts mid-burst; first grant after release follows REQ-016 from rr_ptr=0.

Configuration
REQ-027 SHALL use macro ARB_STATS_EN: when defined, beat_count slice i increments by 1 per accepted beat of requester i, saturating at 16'hFFFF.
REQ-028 SHALL, when ARB_STATS_EN is undefined, tie beat_count to all-zero and synthesize no counter logic.

Verification
REQ-029 SHALL test: req=4'b0001 held, no stall, 10 beats data 1..10 -> fifo_wr_en high 10 cycles, data 1..10 in order, gnt[0] continuous.
REQ-030 SHALL test: req=4'b1111 held, BURST_LEN=4 -> grant order 0,1,2,3,0 with 4 beats each, no idle cycle between owners.
REQ-031 SHALL test: req=4'b0101 held, req[0] dropped after 2 beats -> grant moves to 2 next cycle, rr_ptr=1.
REQ-032 SHALL test: fifo_full=1 for 3 cycles during grant to 1 -> no fifo_wr_en during stall, gnt[1] held, burst resumes with remaining beats.
REQ-033 SHALL test: rst low at beat 2 of a burst -> all outputs 0 immediately; after release with req=4'b0110, requester 1 granted first.
REQ-034 SHALL test with ARB_STATS_EN defined: 20 beats from requester 3 -> beat_count[63:48]=20, other slices 0; undefined -> all slices 0.
